// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : fifo_arb_pkg                                            |
// | Description: Shared types and default sizing for the FIFO write-port |
// |              arbiter (fifo_wr_arbiter, rr_pick).                     |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package fifo_arb_pkg;

  // Default sizing, matching the FIFO this arbiter normally sits in front of
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_BURST  = 4;
  localparam int DEF_CNT_W      = 16;

  // Arbiter control state: waiting for a request, or streaming one owner
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of the per-burst beat counter; never narrower than one bit so a
  // MAX_BURST of 1 still yields a legal vector.
  function automatic int beat_cnt_bits(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : rr_pick                                                 |
// | Description: Combinational round-robin search. Starting one past     |
// |              the last owner, returns the first set request bit,      |
// |              wrapping around the request vector.                     |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic                       any_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Cyclic scan: offset 1 is highest priority, offset NUM_REQ (last itself)
  // is lowest, so a lone requester can still win back the grant.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    any_o    = 1'b0;
    idx_o    = last_i;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_i) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o = 1'b1;
        idx_o = cand_idx;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : fifo_wr_arbiter                                         |
// | Description: Shares one FIFO write port between NUM_REQ producers.   |
// |              Round-robin grants with bursts capped at MAX_BURST      |
// |              words, full-aware write enable, and sticky checking of  |
// |              the FIFO's wr_ack / overflow responses.                 |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // producer side
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          busy,
  // FIFO write side
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  // status
  input  logic                          err_clr,
  output logic [CNT_W-1:0]              words_written,
  output logic                          err_ack,
  output logic                          err_overflow
);

  localparam int                IDX_W       = $clog2(NUM_REQ);
  localparam int                BEAT_W      = beat_cnt_bits(MAX_BURST);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  RESET_OWNER = IDX_W'(NUM_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [BEAT_W-1:0] cnt_q,   cnt_d;
  logic              exp_q;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              err_ack_q, err_ack_d;
  logic              err_ovf_q, err_ovf_d;

  logic                  pick_any;
  logic [IDX_W-1:0]      pick_idx;
  logic                  owner_req;
  logic [FIFO_WIDTH-1:0] req_word [NUM_REQ];

  // Split the flat producer data bus into one word per requester
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_word[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // Next owner candidate, searched from the slot after the current owner
  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i  (req),
    .last_i (owner_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  assign owner_req = req[owner_q];
  assign busy      = (state_q == BURST);
  assign owner_id  = owner_q;

  // Write only while bursting, the owner still offers a word, and the FIFO
  // has room; the FIFO side sees nothing at all outside a burst.
  assign fifo_wr_en   = busy & owner_req & ~fifo_full;
  assign fifo_data_in = busy ? req_word[owner_q] : '0;

  // Only the current owner is acknowledged, and only for a real write
  always_comb begin
    ack          = '0;
    ack[owner_q] = fifo_wr_en;
  end

  // Grant/burst sequencing: IDLE always costs one bubble cycle before the
  // first write so the new owner is registered before it drives the FIFO.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!owner_req) begin
          state_d = IDLE;
        end else if (fifo_wr_en) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO response checking: a registered wr_ack must track the previous
  // cycle's wr_en exactly. A fresh error outranks a simultaneous clear.
  always_comb begin
    err_ack_d = (err_ack_q & ~err_clr) | (exp_q ^ fifo_wr_ack);
    err_ovf_d = (err_ovf_q & ~err_clr) | fifo_overflow;
    words_d   = words_q + CNT_W'(fifo_wr_ack);
  end

  // Arbiter state; reset abandons any burst and returns priority to slot 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= RESET_OWNER;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response tracking and sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= 1'b0;
      words_q   <= '0;
      err_ack_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      exp_q     <= fifo_wr_en;
      words_q   <= words_d;
      err_ack_q <= err_ack_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign words_written = words_q;
  assign err_ack       = err_ack_q;
  assign err_overflow  = err_ovf_q;

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_fifo_wr_arbiter                                      |
// | Description: Self-checking bench for fifo_wr_arbiter: a fixed vector |
// |              table, directed multi-cycle sequences and randomized    |
// |              traffic compared against a behavioural model.           |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*W-1:0]    req_data;
  logic [N-1:0]      ack;
  logic [1:0]        owner_id;
  logic              busy;
  logic [W-1:0]      fifo_data_in;
  logic              fifo_wr_en;
  logic              fifo_full;
  logic              fifo_wr_ack;
  logic              fifo_overflow;
  logic              err_clr;
  logic [CW-1:0]     words_written;
  logic              err_ack;
  logic              err_overflow;

  int n_vec = 0;
  int n_bad = 0;

  // behavioural model state
  bit m_busy;
  int m_owner;
  int m_cnt;
  int m_words;
  bit m_exp;
  bit m_eack;
  bit m_eovf;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .FIFO_WIDTH (W),
    .NUM_REQ    (N),
    .MAX_BURST  (MB),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .owner_id      (owner_id),
    .busy          (busy),
    .fifo_data_in  (fifo_data_in),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_full     (fifo_full),
    .fifo_wr_ack   (fifo_wr_ack),
    .fifo_overflow (fifo_overflow),
    .err_clr       (err_clr),
    .words_written (words_written),
    .err_ack       (err_ack),
    .err_overflow  (err_overflow)
  );

  typedef struct {
    logic [N-1:0] r;
    bit           e_busy;
    bit           e_wr;
    logic [N-1:0] e_ack;
    int           e_owner;
    int           e_words;
    logic [W-1:0] e_data;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int i);
    return req_data[i*W +: W];
  endfunction

  function automatic bit m_wr();
    return m_busy && req[m_owner] && !fifo_full;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = N - 1;
    m_cnt   = 0;
    m_words = 0;
    m_exp   = 0;
    m_eack  = 0;
    m_eovf  = 0;
  endtask

  // am: 0 = FIFO acks like a healthy FIFO, 1 = ack forced low, 2 = forced high
  task automatic set_in(input logic [N-1:0] r, input bit f, input bit ov,
                        input bit clr, input int am);
    req           = r;
    fifo_full     = f;
    fifo_overflow = ov;
    err_clr       = clr;
    fifo_wr_ack   = (am == 0) ? m_exp : (am == 2);
    #1;
  endtask

  task automatic check_model();
    bit           w;
    logic [N-1:0] ea;
    logic [W-1:0] ed;
    w  = m_wr();
    ea = w ? (N'(1) << m_owner) : '0;
    ed = m_busy ? word_of(m_owner) : '0;
    chk("wr_en",        fifo_wr_en,    w);
    chk("ack",          ack,           ea);
    chk("data_in",      fifo_data_in,  ed);
    chk("busy",         busy,          m_busy);
    chk("owner_id",     owner_id,      m_owner);
    chk("words",        words_written, m_words);
    chk("err_ack",      err_ack,       m_eack);
    chk("err_overflow", err_overflow,  m_eovf);
  endtask

  // Clock edge plus the model's view of what that edge does
  task automatic advance();
    bit w;
    bit found;
    int c;
    w = m_wr();
    @(posedge clk);
    m_eack = (m_eack && !err_clr) || (m_exp != fifo_wr_ack);
    m_eovf = (m_eovf && !err_clr) || fifo_overflow;
    if (fifo_wr_ack) m_words = (m_words + 1) % (1 << CW);
    m_exp = w;
    if (!m_busy) begin
      if (req != '0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_owner + k) % N;
          if (!found && req[c]) begin
            found   = 1;
            m_owner = c;
          end
        end
        m_cnt  = 0;
        m_busy = 1;
      end
    end else if (!req[m_owner]) begin
      m_busy = 0;
    end else if (w) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_cnt  = 0;
        m_busy = 0;
      end
    end
    #1;
  endtask

  task automatic step(input logic [N-1:0] r, input bit f, input bit ov,
                      input bit clr, input int am);
    set_in(r, f, ov, clr, am);
    check_model();
    advance();
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy",   busy,          1'b0);
    chk("rst_wr_en",  fifo_wr_en,    1'b0);
    chk("rst_ack",    ack,           '0);
    chk("rst_data",   fifo_data_in,  '0);
    chk("rst_owner",  owner_id,      N - 1);
    chk("rst_words",  words_written, '0);
    chk("rst_errack", err_ack,       1'b0);
    chk("rst_errovf", err_overflow,  1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int grants[$];
    int bursts[$];
    int wcnt;
    bit prev_busy;
    logic [N-1:0] rr;

    rst_n         = 1'b0;
    req           = '0;
    req_data      = '0;
    fifo_full     = 1'b0;
    fifo_wr_ack   = 1'b0;
    fifo_overflow = 1'b0;
    err_clr       = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // ---- single requester, three words, fixed expectations ----
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'hA5A5};
    tbl[0] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 3, 0, 16'h0000};
    tbl[1] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 0, 0, 16'hA5A5};
    tbl[2] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 0, 0, 16'hA5A5};
    tbl[3] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 0, 1, 16'hA5A5};
    tbl[4] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 0, 2, 16'hA5A5};
    tbl[5] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 0, 3, 16'h0000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(tbl[i].r, 1'b0, 1'b0, 1'b0, 0);
      chk("t1_busy",  busy,          tbl[i].e_busy);
      chk("t1_wr_en", fifo_wr_en,    tbl[i].e_wr);
      chk("t1_ack",   ack,           tbl[i].e_ack);
      chk("t1_owner", owner_id,      tbl[i].e_owner);
      chk("t1_words", words_written, tbl[i].e_words);
      chk("t1_data",  fifo_data_in,  tbl[i].e_data);
      check_model();
      advance();
    end

    // ---- all requesting: owners 0,1,2,3,0, four writes per burst ----
    do_reset();
    prev_busy = 1'b0;
    wcnt      = 0;
    for (int c = 0; c < 25; c++) begin
      set_in(4'b1111, 1'b0, 1'b0, 1'b0, 0);
      check_model();
      if (busy && !prev_busy) begin
        if (grants.size() > 0) bursts.push_back(wcnt);
        grants.push_back(int'(owner_id));
        wcnt = 0;
      end
      if (fifo_wr_en) wcnt++;
      prev_busy = busy;
      advance();
    end
    chk("rr_grant_count", grants.size(), 5);
    chk("rr_burst_count", bursts.size(), 4);
    for (int i = 0; i < grants.size() && i < 5; i++) chk("rr_owner", grants[i], i % N);
    for (int i = 0; i < bursts.size(); i++) chk("rr_burst_len", bursts[i], MB);

    // ---- owner 2 stalled by full for 5 cycles mid-burst ----
    do_reset();
    for (int c = 0; c < 13; c++) step(4'b1111, 1'b0, 1'b0, 1'b0, 0);
    for (int c = 0; c < 5; c++) begin
      set_in(4'b1111, 1'b1, 1'b0, 1'b0, 0);
      check_model();
      chk("stall_wr_en", fifo_wr_en, 1'b0);
      chk("stall_ack",   ack,        '0);
      chk("stall_owner", owner_id,   2);
      advance();
    end
    wcnt = 0;
    for (int c = 0; c < 3; c++) begin
      set_in(4'b1111, 1'b0, 1'b0, 1'b0, 0);
      check_model();
      if (fifo_wr_en && owner_id == 2'd2) wcnt++;
      advance();
    end
    chk("stall_resume_words", wcnt, 2);

    // ---- owner 1 releases after two words; requester 2 is next ----
    do_reset();
    for (int c = 0; c < 8; c++) step(4'b1111, 1'b0, 1'b0, 1'b0, 0);
    set_in(4'b1101, 1'b0, 1'b0, 1'b0, 0);
    check_model();
    chk("rel_wr_en", fifo_wr_en, 1'b0);
    chk("rel_busy",  busy,       1'b1);
    advance();
    set_in(4'b1101, 1'b0, 1'b0, 1'b0, 0);
    chk("rel_idle", busy, 1'b0);
    check_model();
    advance();
    set_in(4'b1101, 1'b0, 1'b0, 1'b0, 0);
    check_model();
    chk("rel_next_owner", owner_id, 2);
    advance();

    // ---- ack / overflow error flags ----
    do_reset();
    step(4'b0001, 1'b0, 1'b0, 1'b0, 0);
    step(4'b0001, 1'b0, 1'b0, 1'b0, 0);
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1);           // missing wr_ack
    set_in(4'b0000, 1'b0, 1'b1, 1'b0, 0);          // overflow pulse
    chk("err_ack_set", err_ack, 1'b1);
    check_model();
    advance();
    for (int c = 0; c < 2; c++) begin
      set_in(4'b0000, 1'b0, 1'b0, 1'b0, 0);
      chk("err_ack_sticky", err_ack,      1'b1);
      chk("err_ovf_sticky", err_overflow, 1'b1);
      check_model();
      advance();
    end
    step(4'b0000, 1'b0, 1'b1, 1'b1, 0);            // clear vs new overflow
    set_in(4'b0000, 1'b0, 1'b0, 1'b0, 0);
    chk("clr_ack",       err_ack,      1'b0);
    chk("clr_ovf_wins",  err_overflow, 1'b1);
    check_model();
    advance();
    step(4'b0000, 1'b0, 1'b0, 1'b0, 2);            // unexpected wr_ack
    step(4'b0000, 1'b0, 1'b0, 1'b1, 0);
    set_in(4'b0000, 1'b0, 1'b0, 1'b0, 0);
    chk("clr_both_ack", err_ack,      1'b0);
    chk("clr_both_ovf", err_overflow, 1'b0);
    check_model();
    advance();

    // ---- async reset mid-burst, then requester 0 wins first ----
    do_reset();
    for (int c = 0; c < 3; c++) step(4'b1111, 1'b0, 1'b0, 1'b0, 0);
    chk("pre_rst_busy", busy, 1'b1);
    do_reset();
    step(4'b1111, 1'b0, 1'b0, 1'b0, 0);
    set_in(4'b1111, 1'b0, 1'b0, 1'b0, 0);
    chk("post_rst_owner", owner_id, 0);
    check_model();
    advance();

    // ---- randomized traffic against the model ----
    do_reset();
    rr = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) req_data = {$urandom, $urandom};
      step(rr,
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 25) == 0),
           ($urandom_range(0, 50) == 0) ? int'($urandom_range(1, 2)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
